// File: rtl/scan_decoder.sv
// One-hot select decoder with registered outputs.
// Direct mode decodes sel; scan mode walks every line with a fixed dwell.
module scan_decoder #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   sel,
  output logic [2**N-1:0] out,
  output logic [N-1:0]   cur_idx,
  output logic           wrap
);

  localparam int M  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [M-1:0]  ONE      = 1;
  localparam logic [M-1:0]  INACTIVE = {M{ACTIVE_LOW != 0}};
  localparam logic [CW-1:0] LAST     = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  idx_n;
  logic [M-1:0]  hot_n;
  logic [M-1:0]  out_n;
  logic          wrap_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= INACTIVE;
      cur_idx <= '0;
      wrap    <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      out     <= out_n;
      cur_idx <= idx_n;
      wrap    <= wrap_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = IDLE;
    idx_n   = cur_idx;
    cnt_n   = '0;
    wrap_n  = 1'b0;
    hot_n   = '0;
    if (en) state_n = mode ? SCAN : DIRECT;
    unique case (state_n)
      IDLE: begin
        hot_n = '0;
      end
      DIRECT: begin
        idx_n = sel;
        hot_n = ONE << sel;
      end
      SCAN: begin
        // Entering scan always restarts at line 0.
        if (state != SCAN) begin
          idx_n = '0;
        end else if (cnt == LAST) begin
          idx_n  = cur_idx + 1'b1;
          wrap_n = &cur_idx;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        hot_n = ONE << idx_n;
      end
      default: begin
        hot_n = '0;
      end
    endcase
    out_n = (ACTIVE_LOW != 0) ? ~hot_n : hot_n;
  end

endmodule
